// File: rtl/mem_pkg.sv
// Shared definitions for the memory subsystem: block geometry and arbiter state types.
package mem_pkg;

  localparam int unsigned BLOCK_ADDR_W = 6;
  localparam int unsigned BLOCK_DATA_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StDAccess,
    StIAccess,
    StDResp,
    StIResp
  } arb_state_t;

  typedef enum logic {
    GrantD,
    GrantI
  } grant_t;

endpackage

// File: rtl/rr_select2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the one not granted last wins.
module rr_select2
  import mem_pkg::*;
(
  input  logic   req_d,
  input  logic   req_i,
  input  grant_t last_grant,
  output logic   grant_d,
  output logic   grant_i
);

  always_comb begin
    grant_d = req_d && (!req_i || (last_grant == GrantI));
    grant_i = req_i && (!req_d || (last_grant == GrantD));
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one BUSYWAIT-style main-memory port between the icache and dcache, serialising
// block transfers with round-robin fairness.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = BLOCK_ADDR_W,
  parameter int unsigned DATA_W = BLOCK_DATA_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  arb_state_t        state_q;
  grant_t            last_grant_q;
  logic              started_q;
  logic [DATA_W-1:0] i_readdata_q;
  logic [DATA_W-1:0] d_readdata_q;

  logic d_req;
  logic grant_d;
  logic grant_i;

  assign d_req = D_READ | D_WRITE;

  rr_select2 u_rr_select2 (
    .req_d      (d_req),
    .req_i      (I_READ),
    .last_grant (last_grant_q),
    .grant_d    (grant_d),
    .grant_i    (grant_i)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StIdle;
      last_grant_q <= GrantI;
      started_q    <= 1'b0;
      i_readdata_q <= '0;
      d_readdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          started_q <= 1'b0;
          if (grant_d) begin
            state_q      <= StDAccess;
            last_grant_q <= GrantD;
          end else if (grant_i) begin
            state_q      <= StIAccess;
            last_grant_q <= GrantI;
          end
        end
        StDAccess: begin
          started_q <= 1'b1;
          // First cycle is ignored: memory may not have raised BUSYWAIT yet.
          if (started_q && !MEM_BUSYWAIT) begin
            if (D_READ) d_readdata_q <= MEM_READDATA;
            state_q <= StDResp;
          end
        end
        StIAccess: begin
          started_q <= 1'b1;
          if (started_q && !MEM_BUSYWAIT) begin
            if (I_READ) i_readdata_q <= MEM_READDATA;
            state_q <= StIResp;
          end
        end
        StDResp: state_q <= StIdle;
        StIResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    if (state_q == StDAccess) begin
      MEM_READ      = D_READ;
      MEM_WRITE     = D_WRITE;
      MEM_ADDRESS   = D_ADDRESS;
      MEM_WRITEDATA = D_WRITEDATA;
    end else if (state_q == StIAccess) begin
      MEM_READ    = I_READ;
      MEM_ADDRESS = I_ADDRESS;
    end
  end

  // Stall depends only on the request and registered state, never on MEM_BUSYWAIT.
  assign I_BUSYWAIT = I_READ && (state_q != StIResp);
  assign D_BUSYWAIT = d_req && (state_q != StDResp);
  assign I_READDATA = i_readdata_q;
  assign D_READDATA = d_readdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected responses, a negedge monitor
// pops and compares them whenever a port's BUSYWAIT drops while it is requesting.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        I_READ;
  logic [5:0]  I_ADDRESS;
  logic [31:0] I_READDATA;
  logic        I_BUSYWAIT;
  logic        D_READ;
  logic        D_WRITE;
  logic [5:0]  D_ADDRESS;
  logic [31:0] D_WRITEDATA;
  logic [31:0] D_READDATA;
  logic        D_BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  mem_arbiter dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .I_READ        (I_READ),
    .I_ADDRESS     (I_ADDRESS),
    .I_READDATA    (I_READDATA),
    .I_BUSYWAIT    (I_BUSYWAIT),
    .D_READ        (D_READ),
    .D_WRITE       (D_WRITE),
    .D_ADDRESS     (D_ADDRESS),
    .D_WRITEDATA   (D_WRITEDATA),
    .D_READDATA    (D_READDATA),
    .D_BUSYWAIT    (D_BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Main memory model: busy for mem_lat cycles of a held command, then ready.
  logic [31:0] mem [64];
  int          mem_lat = 5;
  int          mcnt;
  logic        mem_load;

  function automatic logic [31:0] init_word(input int i);
    return (i == 5) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
  endfunction

  always @(posedge CLK) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (MEM_WRITE && (mcnt == mem_lat)) begin
      mem[MEM_ADDRESS] <= MEM_WRITEDATA;
    end
    if (RESET) mcnt <= 0;
    else if (MEM_READ || MEM_WRITE) mcnt <= mcnt + 1;
    else mcnt <= 0;
  end

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mcnt < mem_lat);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  typedef struct {
    bit          port_i;
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cycles;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit p, input bit wr, input logic [5:0] a, input logic [31:0] wd,
                      input logic [31:0] rd);
    exp_t e;
    e.port_i = p;
    e.wr     = wr;
    e.addr   = a;
    e.wdata  = wd;
    e.rdata  = rd;
    e.cycles = mem_lat + 1;
    sb.push_back(e);
  endtask

  // Monitor: tracks the memory command and checks each response cycle.
  int          cmd_cycles = 0;
  logic [5:0]  last_addr;
  logic        last_wr;
  logic [31:0] last_wdata;
  bit          d_ev;
  bit          i_ev;
  exp_t        cur;

  initial begin
    forever begin
      @(negedge CLK);
      if (RESET) begin
        cmd_cycles = 0;
      end else begin
        if (MEM_READ || MEM_WRITE) begin
          cmd_cycles++;
          last_addr  = MEM_ADDRESS;
          last_wr    = MEM_WRITE;
          last_wdata = MEM_WRITEDATA;
        end
        if (!(D_READ || D_WRITE)) chk("d_busywait_idle", 32'(D_BUSYWAIT), 32'd0);
        if (!I_READ) chk("i_busywait_idle", 32'(I_BUSYWAIT), 32'd0);
        d_ev = (D_READ || D_WRITE) && !D_BUSYWAIT;
        i_ev = I_READ && !I_BUSYWAIT;
        if (d_ev || i_ev) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got d=%0b i=%0b expected none at %0t",
                     d_ev, i_ev, $time);
          end else begin
            cur = sb.pop_front();
            chk("resp_port", 32'(i_ev), 32'(cur.port_i));
            chk("mem_address", 32'(last_addr), 32'(cur.addr));
            chk("mem_write", 32'(last_wr), 32'(cur.wr));
            chk("readdata", i_ev ? I_READDATA : D_READDATA, cur.rdata);
            chk("cmd_cycles", 32'(cmd_cycles), 32'(cur.cycles));
            if (cur.wr) chk("mem_writedata", last_wdata, cur.wdata);
          end
          cmd_cycles = 0;
        end
      end
    end
  end

  task automatic wait_port(input bit p);
    for (int n = 0; n < 300; n++) begin
      @(negedge CLK);
      if (p ? (I_READ && !I_BUSYWAIT) : ((D_READ || D_WRITE) && !D_BUSYWAIT)) return;
    end
    checks++;
    errors++;
    $display("FAIL resp_timeout: got no response expected port %0d within 300 cycles", p);
  endtask

  task automatic do_d(input bit wr, input logic [5:0] a, input logic [31:0] wd, input bit drop);
    D_ADDRESS   = a;
    D_WRITEDATA = wd;
    D_READ      = !wr;
    D_WRITE     = wr;
    wait_port(1'b0);
    @(posedge CLK);
    #1;
    if (drop) begin
      D_READ  = 1'b0;
      D_WRITE = 1'b0;
    end
  endtask

  task automatic do_i(input logic [5:0] a, input bit drop);
    I_ADDRESS = a;
    I_READ    = 1'b1;
    wait_port(1'b1);
    @(posedge CLK);
    #1;
    if (drop) I_READ = 1'b0;
  endtask

  task automatic pulse_reset();
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET       = 1'b1;
    mem_load    = 1'b1;
    I_READ      = 1'b0;
    I_ADDRESS   = '0;
    D_READ      = 1'b0;
    D_WRITE     = 1'b0;
    D_ADDRESS   = '0;
    D_WRITEDATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_mem_read", 32'(MEM_READ), 32'd0);
    chk("rst_mem_write", 32'(MEM_WRITE), 32'd0);
    chk("rst_mem_address", 32'(MEM_ADDRESS), 32'd0);
    chk("rst_mem_writedata", MEM_WRITEDATA, 32'd0);
    chk("rst_i_readdata", I_READDATA, 32'd0);
    chk("rst_d_readdata", D_READDATA, 32'd0);
    D_READ = 1'b1;
    I_READ = 1'b1;
    #1;
    chk("rst_d_busywait_held", 32'(D_BUSYWAIT), 32'd1);
    chk("rst_i_busywait_held", 32'(I_BUSYWAIT), 32'd1);
    D_READ = 1'b0;
    I_READ = 1'b0;
    @(posedge CLK);
    #1;
    RESET    = 1'b0;
    mem_load = 1'b0;

    // Lone D read, L=5.
    mem_lat = 5;
    push(1'b0, 1'b0, 6'h05, 32'h0, 32'hDEADBEEF);
    do_d(1'b0, 6'h05, 32'h0, 1'b1);

    // D write leaves D_READDATA alone, then read it back.
    push(1'b0, 1'b1, 6'h3F, 32'h12345678, 32'hDEADBEEF);
    do_d(1'b1, 6'h3F, 32'h12345678, 1'b1);
    push(1'b0, 1'b0, 6'h3F, 32'h0, 32'h12345678);
    do_d(1'b0, 6'h3F, 32'h0, 1'b1);

    // Simultaneous requests after reset: D first, then I.
    pulse_reset();
    push(1'b0, 1'b0, 6'h02, 32'h0, 32'hC0DE0002);
    push(1'b1, 1'b0, 6'h01, 32'h0, 32'hC0DE0001);
    fork
      do_d(1'b0, 6'h02, 32'h0, 1'b1);
      do_i(6'h01, 1'b1);
    join

    // Continuous contention for 6 transfers must alternate.
    pulse_reset();
    mem_lat = 3;
    for (int k = 0; k < 3; k++) begin
      push(1'b0, 1'b0, 6'h08 + 6'(k), 32'h0, 32'hC0DE0008 + 32'(k));
      push(1'b1, 1'b0, 6'h20 + 6'(k), 32'h0, 32'hC0DE0020 + 32'(k));
    end
    fork
      begin
        for (int k = 0; k < 3; k++) do_d(1'b0, 6'h08 + 6'(k), 32'h0, k == 2);
      end
      begin
        for (int j = 0; j < 3; j++) do_i(6'h20 + 6'(j), j == 2);
      end
    join

    // RESET on the 3rd ACCESS cycle of a D read, then restart.
    mem_lat = 5;
    push(1'b0, 1'b0, 6'h07, 32'h0, 32'hC0DE0007);
    @(posedge CLK);
    #1;
    D_ADDRESS = 6'h07;
    D_READ    = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("pre_reset_mem_read", 32'(MEM_READ), 32'd1);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("mid_reset_mem_read", 32'(MEM_READ), 32'd0);
    chk("mid_reset_d_readdata", D_READDATA, 32'd0);
    chk("mid_reset_d_busywait", 32'(D_BUSYWAIT), 32'd1);
    RESET = 1'b0;
    wait_port(1'b0);
    @(posedge CLK);
    #1;
    D_READ = 1'b0;

    // Back-to-back I reads: exactly one IDLE cycle between them.
    push(1'b1, 1'b0, 6'h10, 32'h0, 32'hC0DE0010);
    push(1'b1, 1'b0, 6'h11, 32'h0, 32'hC0DE0011);
    do_i(6'h10, 1'b0);
    I_ADDRESS = 6'h11;
    @(negedge CLK);
    chk("b2b_idle_mem_read", 32'(MEM_READ), 32'd0);
    chk("b2b_idle_i_busywait", 32'(I_BUSYWAIT), 32'd1);
    @(negedge CLK);
    chk("b2b_access_mem_read", 32'(MEM_READ), 32'd1);
    chk("b2b_access_mem_address", 32'(MEM_ADDRESS), 32'h11);
    wait_port(1'b1);
    @(posedge CLK);
    #1;
    I_READ = 1'b0;

    repeat (4) @(posedge CLK);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single main-memory port between the instruction cache (read-only) and the data cache (read/write). It sits between both cache controllers and main memory. It serialises block transfers with round-robin fairness and presents each cache with the memory's BUSYWAIT-style handshake.

## Interface
- ADDR_W, 6: block address width (64 blocks)
- DATA_W, 32: block width in bits (one 4-byte block per transfer)
- CLK  in  1  system clock, all state changes on posedge
- RESET  in  1  synchronous, active-high; clock CLK
- I_READ  in  1  icache block-read request, held until I_BUSYWAIT low
- I_ADDRESS  in  ADDR_W  icache block address
- I_READDATA  out  DATA_W  block returned to icache, valid in I-RESP cycle
- I_BUSYWAIT  out  1  icache stall
- D_READ, D_WRITE  in  1 each  dcache request, mutually exclusive, held until D_BUSYWAIT low
- D_ADDRESS  in  ADDR_W  dcache block address
- D_WRITEDATA  in  DATA_W  write-back block
- D_READDATA  out  DATA_W  block returned to dcache, valid in D-RESP cycle
- D_BUSYWAIT  out  1  dcache stall
- MEM_READ, MEM_WRITE  out  1 each  main-memory command
- MEM_ADDRESS  out  ADDR_W  forwarded from granted requester
- MEM_WRITEDATA  out  DATA_W  forwarded D_WRITEDATA
- MEM_READDATA  in  DATA_W  memory read data
- MEM_BUSYWAIT  in  1  memory busy; rises no later than the first cycle a command is seen

## Operation
- States: IDLE, D_ACCESS, I_ACCESS, D_RESP, I_RESP.
- IDLE: when exactly one request is present, go to the matching ACCESS state. When both are present, grant the requester that is not LAST_GRANT. No request: stay.
- Grant sets LAST_GRANT (D or I).
- ACCESS: MEM_* driven from the granted requester. Commands and address are combinational from state plus the requester's inputs. The other requester's inputs are ignored.
- STARTED flag: cleared on entry to ACCESS; set after the first ACCESS cycle.
- Completion: a posedge in ACCESS with STARTED=1 and MEM_BUSYWAIT=0.
  - Capture MEM_READDATA into the granted port's readdata register.
  - Go to RESP.
- RESP, one cycle:
  - MEM_READ and MEM_WRITE are 0.
  - The granted port's BUSYWAIT is low and its readdata is valid.
  - Next state is IDLE.
- X_BUSYWAIT = (X request asserted) AND NOT (state == X_RESP). This is combinational, so a stall is seen in the same cycle the request rises.
- Writes: D_WRITE forwards D_WRITEDATA. D_READDATA is not updated on a write and holds its previous value.
- A request dropped during ACCESS is illegal. The transfer still completes, and the data is discarded.
- A request still asserted in IDLE after RESP is a new transfer.

## Timing
- Reset values: state IDLE, LAST_GRANT=I (so D wins the first tie), STARTED=0, MEM_READ=MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, I_READDATA=D_READDATA=0.
- Reset busywait: X_BUSYWAIT follows its request, so it is high if the request is held.
- Latency: request seen at edge e0 → ACCESS from e0. With memory busy for L cycles, completion is at edge e0+L+1, RESP lasts one cycle, and IDLE returns at e0+L+2.
- Two back-to-back requests from the same port incur one IDLE bubble.
- Simultaneous requests: the loser keeps BUSYWAIT high throughout, and its grant begins in the IDLE cycle after the winner's RESP.
- RESET during ACCESS or RESP: return to IDLE at that edge and drop the memory command; the memory is reset by the same RESET.
- No combinational path from MEM_BUSYWAIT to the X_BUSYWAIT outputs.

## Structure
- Shared package mem_pkg:
  - arb_state_t enum (5 states).
  - Constants BLOCK_ADDR_W=6 and BLOCK_DATA_W=32, also used by the caches and main memory.
- One sub-module is natural: rr_select2, a combinational 2-way round-robin pick from (req_d, req_i, last_grant) to grant.
- The FSM, STARTED flag, data registers and output muxing stay in mem_arbiter.

## Test plan
- D_READ addr 0x05 alone, memory latency L=5, mem[5]=0xDEADBEEF:
  - MEM_READ high for 6 cycles.
  - D_BUSYWAIT falls for exactly one cycle at e0+6.
  - D_READDATA=0xDEADBEEF.
  - I_BUSYWAIT stays 0.
- D_WRITE addr 0x3F, data 0x12345678:
  - MEM_WRITE, MEM_ADDRESS=0x3F and MEM_WRITEDATA=0x12345678 are held until completion.
  - D_READDATA is unchanged.
  - A subsequent read of 0x3F returns 0x12345678.
- I_READ 0x01 and D_READ 0x02 raised in the same cycle after reset:
  - D is served first, then I.
  - I_BUSYWAIT stays high until I_RESP.
  - MEM_ADDRESS sequence is 0x02 then 0x01.
- Both ports request continuously for 6 transfers → grants alternate D, I, D, I, D, I; no port is served twice in a row.
- RESET asserted on the 3rd ACCESS cycle of a D_READ:
  - Next cycle: state IDLE, MEM_READ=0, D_READDATA=0.
  - With D_READ still held, the transfer restarts after RESET falls.
- Back-to-back I_READ 0x10 then 0x11 → exactly one IDLE cycle between I_RESP and the second I_ACCESS.
